// File: rtl/mrr_decoded_stream_merge_pkg.sv
// Shared definitions for the decoded-stream merger: header layout and FSM state encoding.
package mrr_decoded_stream_merge_pkg;

  localparam int NUM_DECODE_PATHWAYS = 4;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } merge_state_e;

  // Header word: magic [31:28], pathway [27:24], timestamp [23:0].
  function automatic logic [31:0] make_header(input logic [3:0] path, input logic [23:0] ts);
    return {HDR_MAGIC, path, ts};
  endfunction

endpackage

// File: rtl/mrr_decoded_stream_merge_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap-around.
module mrr_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant   = PW'((int'(ptr) + i) % N);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrr_decoded_stream_merge.sv
// Packet-level round-robin merge of decoded pathways into one stream, each packet
// prefixed by a source/timestamp header; overlong packets are truncated and drained.
module mrr_decoded_stream_merge
  import mrr_decoded_stream_merge_pkg::*;
#(
  parameter int NUM_PATHWAYS  = NUM_DECODE_PATHWAYS,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               cur_time,
  input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]   i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]   i_tlast,
  output logic [NUM_PATHWAYS-1:0]   i_tready,
  output logic [31:0]               o_tdata,
  output logic                      o_tvalid,
  output logic                      o_tlast,
  input  logic                      o_tready,
  input  logic                      reset_diagnostic_counter,
  output logic [15:0]               pkt_count,
  output logic [15:0]               trunc_count
);

  localparam int PW = (NUM_PATHWAYS > 1) ? $clog2(NUM_PATHWAYS) : 1;
  localparam logic [15:0] WC_LAST = 16'(MAX_PKT_WORDS - 1);

  merge_state_e  state;
  logic [PW-1:0] g, rr_ptr, arb_grant, next_ptr;
  logic [23:0]   ts;
  logic [15:0]   wc;
  logic          any_req, sel_valid, sel_last, at_limit, beat;
  logic [31:0]   sel_data;
  logic          unused_time;

  assign unused_time = ^cur_time[63:24];

  mrr_rr_arbiter #(.N(NUM_PATHWAYS), .PW(PW)) u_arb (
    .req    (i_tvalid),
    .ptr    (rr_ptr),
    .grant  (arb_grant),
    .any_req(any_req)
  );

  assign sel_valid = i_tvalid[g];
  assign sel_last  = i_tlast[g];
  assign sel_data  = i_tdata[32*int'(g) +: 32];
  assign at_limit  = (wc == WC_LAST);
  assign next_ptr  = (g == PW'(NUM_PATHWAYS - 1)) ? '0 : g + 1'b1;
  assign beat      = ((state == ST_DATA) && sel_valid && o_tready) ||
                     ((state == ST_DRAIN) && sel_valid);

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    i_tready = '0;
    case (state)
      ST_HDR: begin
        o_tvalid = 1'b1;
        o_tdata  = make_header(4'(g), ts);
      end
      ST_DATA: begin
        o_tvalid    = sel_valid;
        o_tdata     = sel_data;
        o_tlast     = sel_last | at_limit;
        i_tready[g] = o_tready;
      end
      ST_DRAIN: i_tready[g] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      g           <= '0;
      rr_ptr      <= '0;
      ts          <= '0;
      wc          <= '0;
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          g     <= arb_grant;
          ts    <= cur_time[23:0];
          state <= ST_HDR;
        end
        ST_HDR: if (o_tready) begin
          wc    <= '0;
          state <= ST_DATA;
        end
        ST_DATA: if (beat) begin
          wc <= wc + 16'd1;
          if (sel_last) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else if (at_limit) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (beat && sel_last) begin
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A clear in the same cycle as an increment leaves the counters at zero.
      if (reset_diagnostic_counter) begin
        pkt_count   <= '0;
        trunc_count <= '0;
      end else if ((state == ST_DATA) && beat && (sel_last || at_limit)) begin
        pkt_count <= pkt_count + 16'd1;
        if (!sel_last && (trunc_count != 16'hFFFF))
          trunc_count <= trunc_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mrr_decoded_stream_merge.sv
// Self-checking bench: queued per-pathway sources, output capture, and a packet-level merge model.
module tb_mrr_decoded_stream_merge;

  localparam int NP   = 4;
  localparam int MAXW = 4;
  localparam int SRCD = 256;
  localparam int MPD  = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [63:0]     cur_time;
  logic [32*NP-1:0] i_tdata;
  logic [NP-1:0]   i_tvalid, i_tlast, i_tready;
  logic [31:0]     o_tdata;
  logic            o_tvalid, o_tlast, o_tready;
  logic            reset_diagnostic_counter;
  logic [15:0]     pkt_count, trunc_count;

  mrr_decoded_stream_merge #(.NUM_PATHWAYS(NP), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .cur_time(cur_time),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready),
    .reset_diagnostic_counter(reset_diagnostic_counter),
    .pkt_count(pkt_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Upstream sources (ring buffers of {last, data}) and the packet list the model sees.
  logic [32:0] src_mem [NP][SRCD];
  int          src_rd [NP], src_wr [NP];
  int          mp_len [NP][MPD], mp_id [NP][MPD];
  int          mp_rd [NP], mp_wr [NP];
  int          pkt_seq = 0;
  int          m_ptr = 0;
  logic [23:0] m_ts;
  logic [15:0] exp_pkt = 0;
  int          exp_trunc = 0;

  logic [32:0] exp_q [$];
  logic [32:0] out_q [$];
  int          out_cyc [$];

  logic        rand_ready = 1'b0, ready_fixed = 1'b1, clr_on_last = 1'b0;
  logic [NP-1:0] acc;
  int          cyc = 0, first_v_cyc = -1, multi_err = 0, stab_err = 0;
  logic        stall_pend = 1'b0;
  logic [32:0] stall_word;

  function automatic logic [31:0] mk_word(input int p, input int id, input int i);
    return {4'h5, 4'(p), 8'(id), 16'(i)};
  endfunction

  function automatic bit srcs_empty();
    for (int p = 0; p < NP; p++) if (src_rd[p] != src_wr[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    int id;
    id = pkt_seq++;
    for (int i = 0; i < len; i++) begin
      src_mem[p][src_wr[p] % SRCD] = {(i == len - 1), mk_word(p, id, i)};
      src_wr[p]++;
    end
    mp_len[p][mp_wr[p] % MPD] = len;
    mp_id[p][mp_wr[p] % MPD]  = id;
    mp_wr[p]++;
  endtask

  // Serve pending packets in cyclic order from the pointer; each emits a header and at most MAXW words.
  task automatic build_expected();
    bit found;
    int q, len, id, n;
    do begin
      found = 1'b0;
      for (int k = 0; k < NP && !found; k++) begin
        q = (m_ptr + k) % NP;
        if (mp_rd[q] != mp_wr[q]) found = 1'b1;
      end
      if (found) begin
        len = mp_len[q][mp_rd[q] % MPD];
        id  = mp_id[q][mp_rd[q] % MPD];
        mp_rd[q]++;
        exp_q.push_back({1'b0, 4'hA, 4'(q), m_ts});
        n = (len < MAXW) ? len : MAXW;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mk_word(q, id, i)});
        exp_pkt++;
        if (len > MAXW && exp_trunc < 65535) exp_trunc++;
        m_ptr = (q + 1) % NP;
      end
    end while (found);
  endtask

  task automatic flush_all();
    for (int p = 0; p < NP; p++) begin
      src_rd[p] = src_wr[p];
      mp_rd[p]  = mp_wr[p];
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (!(srcs_empty() && !o_tvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: not idle after %0d cycles", nm, budget);
      flush_all();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, " beats"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s word%0d", nm, i), 64'(out_q[i]), 64'(exp_q[i]));
    chk({nm, " pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
    chk({nm, " trunc_count"}, 64'(trunc_count), 64'(exp_trunc));
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  // Source driver and output monitor: sample just before the edge, update just after it.
  initial begin
    for (int p = 0; p < NP; p++) begin
      src_rd[p] = 0; src_wr[p] = 0; mp_rd[p] = 0; mp_wr[p] = 0;
    end
    i_tvalid = '0; i_tlast = '0; i_tdata = '0;
    o_tready = 1'b1;
    reset_diagnostic_counter = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = i_tvalid & i_tready;
      if (rst_n) begin
        if (o_tvalid && o_tready) begin
          out_q.push_back({o_tlast, o_tdata});
          out_cyc.push_back(cyc);
        end
        if ($countones(i_tready) > 1) multi_err++;
        if (stall_pend && (!o_tvalid || {o_tlast, o_tdata} != stall_word)) stab_err++;
        stall_pend = o_tvalid & !o_tready;
        stall_word = {o_tlast, o_tdata};
        if (first_v_cyc < 0 && |i_tvalid) first_v_cyc = cyc;
      end else begin
        stall_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) src_rd[p]++;
        if (src_rd[p] != src_wr[p]) begin
          i_tvalid[p] = 1'b1;
          {i_tlast[p], i_tdata[32*p +: 32]} = src_mem[p][src_rd[p] % SRCD];
        end else begin
          i_tvalid[p] = 1'b0;
          i_tlast[p]  = 1'b0;
          i_tdata[32*p +: 32] = '0;
        end
      end
      o_tready = rand_ready ? ($urandom_range(0, 99) < 65) : ready_fixed;
      reset_diagnostic_counter = clr_on_last & i_tvalid[0] & i_tlast[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          p;
    int          len;
    logic [63:0] tm;
    logic [31:0] hdr;
    int          nwords;
    int          trunc_inc;
  } vec_t;

  vec_t tbl [5];
  int   hdr_paths [$];
  int   run_trunc;
  bit   in_hdr;

  initial begin
    tbl[0] = '{2,  3, 64'h0000_00FF_0012_3456, 32'hA212_3456, 3, 0};
    tbl[1] = '{1, 10, 64'h1234_5678_9ABC_DEF0, 32'hA1BC_DEF0, 4, 1};
    tbl[2] = '{3,  4, 64'h0000_0000_00AB_CDEF, 32'hA3AB_CDEF, 4, 0};
    tbl[3] = '{0,  1, 64'h0000_0000_0000_0000, 32'hA000_0000, 1, 0};
    tbl[4] = '{3,  5, 64'hFFFF_FFFF_FFFF_FFFF, 32'hA3FF_FFFF, 4, 1};

    rst_n = 1'b0;
    cur_time = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_tvalid", 64'(o_tvalid), 0);
    chk("reset o_tdata", 64'(o_tdata), 0);
    chk("reset i_tready", 64'(i_tready), 0);
    chk("reset pkt_count", 64'(pkt_count), 0);
    chk("reset trunc_count", 64'(trunc_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin with every pathway holding two 2-word packets.
    cur_time = 64'hDEAD_0000_0000_0111;
    m_ts = cur_time[23:0];
    for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) add_pkt(p, 2);
    build_expected();
    wait_idle("rr", 500);
    in_hdr = 1'b1;
    hdr_paths.delete();
    foreach (out_q[i]) begin
      if (in_hdr) hdr_paths.push_back(int'(out_q[i][27:24]));
      in_hdr = out_q[i][32];
    end
    chk("rr grant count", 64'(hdr_paths.size()), 8);
    for (int i = 0; i < 5 && i < hdr_paths.size(); i++)
      chk($sformatf("rr grant%0d", i), 64'(hdr_paths[i]), 64'(i % NP));
    cmp_stream("rr");

    // Single-packet vectors: header format, truncation and exact limit.
    run_trunc = exp_trunc;
    for (int t = 0; t < 5; t++) begin
      cur_time = tbl[t].tm;
      m_ts = tbl[t].tm[23:0];
      add_pkt(tbl[t].p, tbl[t].len);
      build_expected();
      wait_idle($sformatf("vec%0d", t), 200);
      run_trunc += tbl[t].trunc_inc;
      if (out_q.size() > 0) begin
        chk($sformatf("vec%0d header", t), 64'(out_q[0][31:0]), 64'(tbl[t].hdr));
        chk($sformatf("vec%0d data words", t), 64'(out_q.size() - 1), 64'(tbl[t].nwords));
        chk($sformatf("vec%0d final tlast", t), 64'(out_q[out_q.size() - 1][32]), 1);
      end else begin
        chk($sformatf("vec%0d output present", t), 0, 1);
      end
      chk($sformatf("vec%0d trunc total", t), 64'(trunc_count), 64'(run_trunc));
      cmp_stream($sformatf("vec%0d", t));
    end

    // After truncating pathway 1, the next grant goes to pathway 2.
    add_pkt(1, 7);
    build_expected();
    wait_idle("trunc1", 200);
    cmp_stream("trunc1");
    add_pkt(0, 2); add_pkt(2, 2); add_pkt(3, 2);
    build_expected();
    wait_idle("after_trunc", 300);
    chk("next grant after trunc", out_q.size() > 0 ? 64'(out_q[0][27:24]) : 64'hF, 2);
    cmp_stream("after_trunc");

    // Latency: header one cycle after valid is seen, first data one cycle later.
    first_v_cyc = -1;
    add_pkt(0, 3);
    build_expected();
    wait_idle("timing", 200);
    chk("timing beats seen", 64'(out_cyc.size() >= 2), 1);
    if (out_cyc.size() >= 2) begin
      chk("timing header", 64'(out_cyc[0] - first_v_cyc), 1);
      chk("timing data0", 64'(out_cyc[1] - first_v_cyc), 2);
    end
    cmp_stream("timing");

    // Reset in the middle of DATA.
    add_pkt(3, 6);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        #2;
        n++;
      end while (out_q.size() < 3 && n < 50);
      chk("mid-data reached", 64'(out_q.size() >= 3), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst o_tvalid", 64'(o_tvalid), 0);
    chk("rst o_tlast", 64'(o_tlast), 0);
    chk("rst o_tdata", 64'(o_tdata), 0);
    chk("rst i_tready", 64'(i_tready), 0);
    @(negedge clk);
    #1;
    flush_all();
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    m_ptr = 0; exp_pkt = 0; exp_trunc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-rst pkt_count", 64'(pkt_count), 0);
    chk("post-rst trunc_count", 64'(trunc_count), 0);
    chk("post-rst idle", 64'(o_tvalid), 0);

    // Counter clear coinciding with a tlast beat.
    m_ts = cur_time[23:0];
    add_pkt(2, 6);
    add_pkt(1, 2);
    build_expected();
    wait_idle("pre-clear", 200);
    cmp_stream("pre-clear");
    clr_on_last = 1'b1;
    add_pkt(0, 3);
    build_expected();
    wait_idle("clear", 200);
    clr_on_last = 1'b0;
    exp_pkt = 0;
    exp_trunc = 0;
    cmp_stream("clear");

    // Randomized traffic under random backpressure.
    rand_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      cur_time = {$urandom, $urandom};
      m_ts = cur_time[23:0];
      for (int p = 0; p < NP; p++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) add_pkt(p, $urandom_range(1, 7));
      end
      build_expected();
      wait_idle($sformatf("rand%0d", it), 2000);
      cmp_stream($sformatf("rand%0d", it));
    end
    rand_ready = 1'b0;

    chk("single ready only", 64'(multi_err), 0);
    chk("stall stability", 64'(stab_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mrr_decoded_stream_merge.md
# mrr_decoded_stream_merge

Packet-level round-robin merger that sits directly downstream of the per-pathway decoded outputs of the MRR header/decoder stage. It accepts the NUM_PATHWAYS independent 32-bit decoded AXI-Stream packets and emits them as a single stream to the host DMA path. Each forwarded packet is prefixed with one header word that carries the source pathway and a capture timestamp. Overlong packets are truncated and counted.

## Interface
- NUM_PATHWAYS, 4: number of decode pathways merged; equals NUM_DECODE_PATHWAYS from mrr_params; range 1..16.
- MAX_PKT_WORDS, 64: maximum number of data words forwarded per packet, header excluded; range 2..65535.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cur_time  in  64  free-running time; bits [23:0] are latched at grant.
- i_tdata  in  32*NUM_PATHWAYS  decoded words; pathway p occupies [32p+31:32p].
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tlast  in  NUM_PATHWAYS  per-pathway end of packet.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- o_tdata  out  32  merged data.
- o_tvalid  out  1  merged valid.
- o_tlast  out  1  merged end of packet.
- o_tready  in  1  downstream ready.
- reset_diagnostic_counter  in  1  synchronous clear of both counters.
- pkt_count  out  16  packets emitted, wrapping.
- trunc_count  out  16  packets truncated, saturating at 0xFFFF.

## Operation
- The FSM has four states: IDLE, HDR, DATA, DRAIN.
- **IDLE**
  - All i_tready = 0; o_tvalid = 0.
  - If any i_tvalid is high, grant the first valid pathway found searching upward from rr_ptr, with wrap-around.
  - Register grant g and latch ts = cur_time[23:0], then go to HDR.
- **HDR**
  - o_tvalid = 1, o_tlast = 0.
  - o_tdata = {4'hA, g[3:0], ts}: magic in [31:28], pathway index in [27:24], timestamp in [23:0].
  - On o_tready: clear the word counter wc and go to DATA.
- **DATA**
  - Pass-through: o_tvalid = i_tvalid[g], o_tdata = i_tdata[g], i_tready[g] = o_tready. All other i_tready stay 0.
  - o_tlast = i_tlast[g] OR (wc == MAX_PKT_WORDS-1).
  - On each accepted beat, wc increments.
  - Accepted beat with i_tlast[g]: pkt_count++, rr_ptr = (g+1) mod NUM_PATHWAYS, go to IDLE.
  - Accepted beat with wc == MAX_PKT_WORDS-1 and i_tlast[g] low: pkt_count++, trunc_count++ (saturating), go to DRAIN.
  - If i_tlast[g] is high on the word-limit beat, the packet counts as normal, not truncated.
- **DRAIN**
  - o_tvalid = 0; i_tready[g] = 1.
  - Discard beats from pathway g until a beat with i_tlast[g] is accepted.
  - Then rr_ptr = g+1 mod NUM_PATHWAYS and go to IDLE.
- **Counters**
  - reset_diagnostic_counter clears both counters.
  - If it coincides with an increment, the clear wins.
- **Fairness:** a pathway's i_tvalid is ignored until that pathway is granted. No beat is ever accepted from a non-granted pathway.
- **Async reset**
  - Resets the state to IDLE, rr_ptr = 0, g = 0, wc = 0, ts = 0, pkt_count = 0, trunc_count = 0.
  - All outputs are 0 during reset: o_tvalid, o_tlast, o_tdata, i_tready.
  - Reset in the middle of a packet abandons it. No trailing tlast is emitted.

## Timing
- A valid first seen in IDLE at cycle t produces the header with o_tvalid high at t+1.
- The first data word can transfer no earlier than t+2.
- In DATA the path from input to output is combinational: zero latency, one word per cycle at full throughput.
- The header and the state, grant and counter registers are flopped. In HDR, o_tvalid, o_tdata and o_tlast come from registers.
- Packet-to-packet overhead is 2 cycles: the IDLE cycle plus the HDR cycle.
- The outputs obey AXI-Stream rules. In HDR, o_tdata is stable while o_tvalid is high and o_tready is low.
- In DATA, stability follows the upstream pathway, which is itself AXI compliant.
- wc is 16 bits wide and compared against MAX_PKT_WORDS-1.
- rr_ptr and g are each $clog2(NUM_PATHWAYS) bits wide (minimum 1) and are zero-extended to 4 bits in the header.

## Structure
- Header magic 4'hA, the field positions and the state encoding go in the shared mrr_params include.
- Sub-module mrr_rr_arbiter: combinational round-robin priority picker with inputs req[NUM_PATHWAYS-1:0] and ptr, output grant index and any_req.
- Everything else lives in the top module.

## Test plan
- **Single packet:** pathway 2 sends 3 words with cur_time[23:0] = 0x123456.
  - Output is 0xA2123456, then the 3 words, with tlast on the last word; pkt_count = 1.
- **Round robin:** all 4 pathways continuously valid with 2-word packets.
  - Grant order is 0,1,2,3,0; no beat is taken from a non-granted pathway.
- **Truncation:** with MAX_PKT_WORDS = 4, pathway 1 sends 10 words.
  - Output is the header plus 4 words, tlast on word 4; the 6 remaining words are drained with o_tvalid low.
  - trunc_count = 1; the next grant goes to pathway 2.
- **Backpressure:** o_tready toggled at random, including low during HDR.
  - Header and data stay stable while stalled; no duplicated or lost words; compare against a reference queue.
- **Reset and clear:** rst_n asserted mid-DATA.
  - All outputs 0 immediately; after release, state is IDLE and counters are 0.
  - reset_diagnostic_counter asserted on a tlast beat leaves pkt_count = 0.
- **Exact limit:** tlast arrives exactly on the MAX_PKT_WORDS-th word.
  - No DRAIN state, trunc_count unchanged.
